// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Takes the instruction-fetch and data SRAM-like request streams from the
//   CPU-side adapter, arbitrates between them (data has fixed priority) and
//   turns each accepted request into one single-beat AXI read or write on a
//   shared master port. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request (always a word read)
//   inst_rdata/inst_addr_ok/inst_data_ok   fetch accept / data return
//   data_req/data_wr/data_size/data_addr/data_wdata   data request
//   data_rdata/data_addr_ok/data_data_ok   data accept / completion
//   araddr/arsize/arvalid/arready          AXI read address channel
//   rdata/rvalid/rready                    AXI read data channel
//   awaddr/awsize/awvalid/awready          AXI write address channel
//   wdata/wstrb/wvalid/wready              AXI write data channel
//   bvalid/bready                          AXI write response channel
module sram_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI read
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_D = 3'd2;
  localparam logic [2:0] WR_A = 3'd3;
  localparam logic [2:0] WR_B = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        src_q, src_d;       // 1 = data side owns the transaction
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic idle;
  logic aw_fire, w_fire;
  logic rd_done, wr_done;

  // Byte-lane strobes for a lane-aligned write of the given size.
  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  assign idle = (state_q == IDLE);

  // Fixed-priority arbitration: data wins, fetch only when data is quiet.
  assign data_addr_ok = idle & data_req;
  assign inst_addr_ok = idle & inst_req & ~data_req;

  // Read channel
  assign arvalid = (state_q == RD_A);
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign rready  = (state_q == RD_D);

  // Write channel; each half of the AW/W pair drops once it has handshaken.
  assign awvalid = (state_q == WR_A) & ~aw_done_q;
  assign wvalid  = (state_q == WR_A) & ~w_done_q;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;
  assign wstrb   = strb_of(size_q, addr_q[1:0]);
  assign bready  = (state_q == WR_B);

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  // Completion is returned in the same cycle as the AXI response beat.
  assign rd_done = (state_q == RD_D) & rvalid & ~wr_q;
  assign wr_done = (state_q == WR_B) & bvalid & wr_q;

  assign inst_data_ok = rd_done & ~src_q;
  assign data_data_ok = (rd_done | wr_done) & src_q;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          src_d   = 1'b1;
          wr_d    = data_wr;
          // size 3 is carried as a word access
          size_d  = (data_size == 2'd3) ? 2'd2 : data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = data_wr ? WR_A : RD_A;
        end else if (inst_req) begin
          src_d   = 1'b0;
          wr_d    = 1'b0;
          size_d  = 2'd2;
          addr_d  = inst_addr;
          state_d = RD_A;
        end
      end
      RD_A: if (arready) state_d = RD_D;
      RD_D: if (rvalid) state_d = IDLE;
      WR_A: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        // Both halves may finish in the same cycle or in either order.
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_B: if (bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Testbench for sram_axi_bridge: directed scenarios with literal expectations,
// then randomized request/AXI-slave traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference memory (updated from accepted requests) and slave memory
  // (updated from what the DUT actually puts on the AXI write channels).
  logic [31:0] rmem [16];
  logic [31:0] smem [16];

  // Transaction-level model
  bit          mvalid, busy, t_src, t_wr, ar_seen, aw_seen, w_seen;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  int          busy_cyc;

  // AXI slave bookkeeping
  bit          s_ar, s_aw, s_w, s_b;
  int          s_rcnt, s_bcnt;
  logic [31:0] s_araddr, s_awaddr, s_wd;
  logic [3:0]  s_ws;

  bit rnd, issue, i_acc, d_acc;

  // Which byte lanes a request of this size and address touches.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [31:0] a);
    int lo, n;
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      2'd0: begin lo = int'(a[1:0]); n = 1; end
      2'd1: begin lo = a[1] ? 2 : 0; n = 2; end
      default: begin lo = 0; n = 4; end
    endcase
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_slave();
    s_ar = 0; s_aw = 0; s_w = 0; s_b = 0; s_rcnt = 0; s_bcnt = 0;
  endtask

  task automatic model_cycle();
    bit e_iok, e_daok, rd, wrt, e_arv, e_rr, e_awv, e_wv, e_br, e_idok, e_ddok;
    logic [3:0] m;
    e_iok = 0; e_daok = 0; rd = 0; wrt = 0; e_arv = 0; e_rr = 0;
    e_awv = 0; e_wv = 0; e_br = 0; e_idok = 0; e_ddok = 0;
    if (mvalid) begin
      e_iok  = !busy && inst_req && !data_req;
      e_daok = !busy && data_req;
      rd     = busy && !t_wr;
      wrt    = busy && t_wr;
      e_arv  = rd && !ar_seen;
      e_rr   = rd && ar_seen;
      e_awv  = wrt && !aw_seen;
      e_wv   = wrt && !w_seen;
      e_br   = wrt && aw_seen && w_seen;
      e_idok = e_rr && rvalid && !t_src;
      e_ddok = (e_rr && rvalid && t_src) || (e_br && bvalid);
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iok));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      chk("arvalid", 32'(arvalid), 32'(e_arv));
      chk("rready", 32'(rready), 32'(e_rr));
      chk("awvalid", 32'(awvalid), 32'(e_awv));
      chk("wvalid", 32'(wvalid), 32'(e_wv));
      chk("bready", 32'(bready), 32'(e_br));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
      chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
      if (e_arv) begin
        chk("araddr", araddr, t_addr);
        chk("arsize", 32'(arsize), {30'd0, t_size});
      end
      if (e_awv) begin
        chk("awaddr", awaddr, t_addr);
        chk("awsize", 32'(awsize), {30'd0, t_size});
      end
      if (e_wv) begin
        chk("wdata", wdata, t_wdata);
        chk("wstrb", 32'(wstrb), 32'(lane_mask(t_size, t_addr)));
      end
      if (e_idok) chk("inst_rdata", inst_rdata, rdata);
      if (e_ddok && !t_wr) chk("data_rdata", data_rdata, rdata);
      if (rnd && (e_idok || (e_ddok && !t_wr))) chk("rd_mem", rdata, rmem[t_addr[5:2]]);
      if (busy) begin
        busy_cyc++;
        if (busy_cyc == 300) begin
          nchk++; nerr++;
          $display("FAIL txn_timeout: got still busy expected completion at %0t", $time);
        end
      end
    end
    // slave side reacts to what the DUT actually drives
    if (rst) clear_slave();
    else begin
      if (arvalid && arready) begin s_ar = 1; s_araddr = araddr; s_rcnt = $urandom_range(0, 3); end
      if (rvalid && rready) s_ar = 0;
      if (awvalid && awready) begin s_aw = 1; s_awaddr = awaddr; end
      if (wvalid && wready) begin s_w = 1; s_wd = wdata; s_ws = wstrb; end
      if (bvalid && bready) s_b = 0;
      if (s_aw && s_w) begin
        for (int i = 0; i < 4; i++) if (s_ws[i]) smem[s_awaddr[5:2]][8*i +: 8] = s_wd[8*i +: 8];
        s_aw = 0; s_w = 0; s_b = 1; s_bcnt = $urandom_range(0, 3);
      end
    end
    // model advance for the coming clock edge
    if (rst) begin
      mvalid = 1; busy = 0; ar_seen = 0; aw_seen = 0; w_seen = 0; busy_cyc = 0;
    end else if (mvalid) begin
      if (busy) begin
        if (e_arv && arready) ar_seen = 1;
        if (e_awv && awready) aw_seen = 1;
        if (e_wv && wready) w_seen = 1;
        if (e_idok || e_ddok) busy = 0;
      end else if (data_req || inst_req) begin
        busy = 1; ar_seen = 0; aw_seen = 0; w_seen = 0; busy_cyc = 0;
        if (data_req) begin
          t_src = 1; t_wr = data_wr; t_addr = data_addr; t_wdata = data_wdata;
          t_size = (data_size == 2'd3) ? 2'd2 : data_size;
          if (data_wr) begin
            m = lane_mask(t_size, t_addr);
            for (int i = 0; i < 4; i++) if (m[i]) rmem[t_addr[5:2]][8*i +: 8] = t_wdata[8*i +: 8];
          end
        end else begin
          t_src = 0; t_wr = 0; t_size = 2'd2; t_addr = inst_addr;
        end
      end
    end
    if (inst_addr_ok) i_acc = 1;
    if (data_addr_ok) d_acc = 1;
  endtask

  task automatic auto_drive();
    arready = 1'($urandom_range(0, 1));
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    rvalid = 0; rdata = $urandom;
    if (s_ar) begin
      if (s_rcnt == 0) begin rvalid = 1; rdata = smem[s_araddr[5:2]]; end
      else s_rcnt--;
    end
    bvalid = 0;
    if (s_b) begin
      if (s_bcnt == 0) bvalid = 1;
      else s_bcnt--;
    end
    if (inst_req && i_acc) inst_req = 0;
    i_acc = 0;
    if (issue && !inst_req && $urandom_range(0, 2) == 0) begin
      inst_req = 1;
      inst_addr = 32'h1FC0_0000 | (32'($urandom_range(0, 15)) << 2);
    end
    if (data_req && d_acc) data_req = 0;
    d_acc = 0;
    if (issue && !data_req && $urandom_range(0, 2) == 0) begin
      data_req = 1;
      data_wr = 1'($urandom_range(0, 1));
      data_size = 2'($urandom_range(0, 3));
      data_addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
      data_wdata = $urandom;
    end
  endtask

  task automatic pre();
    @(posedge clk);
    #1;
    if (rnd) auto_drive();
  endtask

  task automatic post();
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    logic [31:0] v;
    bit drained;
    rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; arready = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    rnd = 0; issue = 0; i_acc = 0; d_acc = 0; mvalid = 0; busy = 0; busy_cyc = 0;
    clear_slave();
    for (int i = 0; i < 16; i++) begin v = $urandom; rmem[i] = v; smem[i] = v; end

    // reset
    repeat (3) begin pre(); post(); end
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    pre(); rst = 0; post();

    // fetch read, zero wait states
    pre(); inst_req = 1; inst_addr = 32'h1FC0_0000; arready = 1; post();
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    pre(); inst_req = 0; post();
    chk("t1_arvalid", 32'(arvalid), 1);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    chk("t1_arsize", 32'(arsize), 2);
    pre(); arready = 0; rvalid = 1; rdata = 32'h3C08_BFC0; post();
    chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C08_BFC0);
    pre(); rvalid = 0; post();
    chk("t1_dok_pulse", 32'(inst_data_ok), 0);

    // simultaneous requests: data wins, fetch follows
    pre(); inst_req = 1; inst_addr = 32'h1FC0_0004; data_req = 1; data_wr = 0;
    data_size = 2; data_addr = 32'h8000_0004; arready = 1; post();
    chk("t2_data_addr_ok", 32'(data_addr_ok), 1);
    chk("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
    pre(); data_req = 0; post();
    chk("t2_araddr", araddr, 32'h8000_0004);
    chk("t2_busy_no_inst", 32'(inst_addr_ok), 0);
    pre(); rvalid = 1; rdata = 32'h1234_5678; post();
    chk("t2_data_data_ok", 32'(data_data_ok), 1);
    chk("t2_data_rdata", data_rdata, 32'h1234_5678);
    pre(); rvalid = 0; post();
    chk("t2_inst_after", 32'(inst_addr_ok), 1);
    pre(); inst_req = 0; post();
    pre(); rvalid = 1; rdata = 32'hCAFE_0001; post();
    chk("t2_inst_data_ok", 32'(inst_data_ok), 1);
    pre(); rvalid = 0; arready = 0; post();

    // byte write, delayed response
    pre(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003;
    data_wdata = 32'hAB00_0000; awready = 1; wready = 1; post();
    chk("t3_data_addr_ok", 32'(data_addr_ok), 1);
    pre(); data_req = 0; post();
    chk("t3_wstrb", 32'(wstrb), 32'h8);
    chk("t3_awsize", 32'(awsize), 0);
    chk("t3_wdata", wdata, 32'hAB00_0000);
    repeat (5) begin
      pre(); bvalid = 0; post();
      chk("t3_bready_hold", 32'(bready), 1);
      chk("t3_no_early_ok", 32'(data_data_ok), 0);
    end
    pre(); bvalid = 1; post();
    chk("t3_data_data_ok", 32'(data_data_ok), 1);
    pre(); bvalid = 0; awready = 0; wready = 0; post();
    chk("t3_bready_off", 32'(bready), 0);

    // skewed AW/W handshakes, halfword
    pre(); data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h8000_0002;
    data_wdata = 32'h5A5A_0000; post();
    pre(); data_req = 0; wready = 1; post();
    chk("t4_wvalid_c1", 32'(wvalid), 1);
    chk("t5_wstrb_half", 32'(wstrb), 32'hC);
    chk("t5_awsize_half", 32'(awsize), 1);
    pre(); wready = 0; post();
    chk("t4_wvalid_c2", 32'(wvalid), 0);
    chk("t4_awvalid_c2", 32'(awvalid), 1);
    pre(); post();
    chk("t4_awvalid_c3", 32'(awvalid), 1);
    pre(); awready = 1; post();
    chk("t4_awvalid_c4", 32'(awvalid), 1);
    chk("t4_bready_c4", 32'(bready), 0);
    pre(); awready = 0; post();
    chk("t4_bready_c5", 32'(bready), 1);
    chk("t4_awvalid_c5", 32'(awvalid), 0);
    pre(); bvalid = 1; post();
    chk("t4_data_data_ok", 32'(data_data_ok), 1);
    pre(); bvalid = 0; post();

    // both readys together, size 3
    pre(); data_req = 1; data_wr = 1; data_size = 3; data_addr = 32'h8000_0000;
    data_wdata = 32'h0BAD_F00D; post();
    pre(); data_req = 0; awready = 1; wready = 1; post();
    chk("t5_wstrb_sz3", 32'(wstrb), 32'hF);
    chk("t5_awsize_sz3", 32'(awsize), 2);
    pre(); awready = 0; wready = 0; bvalid = 1; post();
    chk("t4_same_bready", 32'(bready), 1);
    chk("t4_same_dok", 32'(data_data_ok), 1);
    pre(); bvalid = 0; post();

    // reset while waiting for read data
    pre(); data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0008; arready = 1; post();
    pre(); data_req = 0; post();
    pre(); arready = 0; rst = 1; post();
    chk("t6_rready_before", 32'(rready), 1);
    pre(); rst = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; post();
    chk("t6_rready", 32'(rready), 0);
    chk("t6_arvalid", 32'(arvalid), 0);
    chk("t6_late_dok", 32'(data_data_ok), 0);
    chk("t6_late_iok", 32'(inst_data_ok), 0);
    pre(); rvalid = 0; post();

    // randomized traffic
    clear_slave(); i_acc = 0; d_acc = 0;
    rnd = 1; issue = 1;
    repeat (4000) begin pre(); post(); end
    issue = 0;
    drained = 0;
    for (int c = 0; c < 500 && !drained; c++) begin
      pre(); post();
      if (!busy && !inst_req && !data_req) drained = 1;
    end
    if (!drained) begin
      nchk++; nerr++;
      $display("FAIL drain: got traffic pending expected idle at %0t", $time);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Downstream of the CPU-side SRAM-like adapter. Accepts the instruction-fetch and data SRAM-like request streams and arbitrates between them. Converts each accepted request into a single-beat AXI read or write on one shared master port. At most one transaction is outstanding at any time.

Parameters:
none. Single-beat transfers only; len, burst and ID fields are tied off outside this block (len=0, burst=INCR, id=0).

Ports:
clk  in  1  clock
rst  in  1  reset
inst_req  in  1  fetch request; read-only, always word-sized
inst_addr  in  32  fetch address
inst_rdata  out  32  fetch read data; valid only with inst_data_ok
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data returned this cycle
data_req  in  1  data request
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word; 3 is treated as 2
data_addr  in  32  data address
data_wdata  in  32  write data, already lane-aligned
data_rdata  out  32  read data; valid only with data_data_ok
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  read data returned or write completed this cycle
araddr  out  32  AXI read address
arsize  out  3  AXI read size = {0, size}
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size = {0, size}
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Reset: rst is synchronous, active-high, on clk.
  - FSM goes to IDLE; aw_done and w_done clear to 0; all latched request registers clear to 0.
  - Consequently every valid, ready, addr_ok and data_ok output is 0.
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_B.
- IDLE arbitration (combinational, fixed priority, data wins):
  - data_addr_ok = data_req.
  - inst_addr_ok = inst_req & ~data_req.
  - Outside IDLE, both addr_ok outputs are 0.
- On acceptance, latch in one cycle: source (inst/data), wr, size, addr, wdata.
  - Inst requests latch wr=0, size=2.
  - Next state: RD_A for a read, WR_A for a write.
- RD_A: arvalid=1; araddr and arsize come from the latched values.
  - On arready, go to RD_D.
- RD_D: rready=1.
  - On rvalid, pulse the source's data_ok combinationally in the same cycle, then go to IDLE.
  - inst_rdata and data_rdata are both driven directly from rdata.
  - rresp is not checked.
- WR_A: awvalid = ~aw_done; wvalid = ~w_done.
  - Set aw_done on awvalid&awready; set w_done on wvalid&wready.
  - Go to WR_B in the cycle both handshakes have completed, including the case where both complete in the same cycle. Clear both flags on that transition.
- WR_B: bready=1.
  - On bvalid, pulse data_data_ok for one cycle, then go to IDLE.
  - bresp is not checked.
- Write strobes (from latched size and addr[1:0]):
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111.
- wdata = latched wdata. awaddr = latched addr, unmodified.
- Turnaround: a new request is accepted no earlier than the cycle after data_ok. The upstream block holds req until it sees addr_ok.
- Minimum latency (all AXI ready/valid already high):
  - read: accept, then AR cycle, then R cycle, giving data_ok 2 cycles after addr_ok;
  - write: same, giving data_ok 2 cycles after addr_ok.
- Starvation: fetch waits while data_req stays high in IDLE. This is accepted; the data side issues one request at a time.
- Reset mid-transaction: the transaction is abandoned with no data_ok. AXI valids drop immediately; this is permitted only under system reset.

Test Plan:
1. Fetch read: inst_req=1, addr=0x1FC00000; arready and rvalid immediate, rdata=0x3C08BFC0 -> inst_addr_ok at cycle 0; araddr=0x1FC00000 with arsize=2 at cycle 1; inst_data_ok=1 with inst_rdata=0x3C08BFC0 at cycle 2.
2. Simultaneous requests: inst_req=1 and data_req=1 (read, 0x80000004) in IDLE -> data_addr_ok=1, inst_addr_ok=0. After data_data_ok, the next IDLE cycle gives inst_addr_ok=1.
3. Byte write to 0x80000003, wdata=0xAB000000 -> wstrb=4'b1000, awsize=0. data_data_ok only after bvalid; with bvalid delayed 5 cycles, bready holds 1 throughout.
4. Skewed AW/W: wready=1 at cycle 1, awready=1 at cycle 4 -> wvalid drops after cycle 1 and awvalid holds through cycle 4. The FSM enters WR_B at cycle 5. Repeat with both readys in the same cycle -> WR_B on the next cycle.
5. Halfword write to 0x80000002 -> wstrb=4'b1100, awsize=1. Size 3 to 0x80000000 -> wstrb=4'b1111, awsize=2.
6. Reset asserted in RD_D before rvalid -> next cycle state is IDLE with every valid and data_ok at 0. A late rvalid produces no data_ok.
